// File: rtl/sata_cmd_sequencer.sv
// Command-layer sequencer: queues application requests and issues them to the transport
// layer one at a time, with bounded retry on done_bad, a WAIT timeout and a result strobe.
module sata_cmd_sequencer #(
    parameter int unsigned QDEPTH_LOG2 = 2,
    parameter int unsigned TIMEOUT     = 20'd1000000,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_val,
    input  logic [2:0]             req_type,
    input  logic [3:0]             req_port,
    output logic                   req_ready,
    output logic [QDEPTH_LOG2:0]   queue_level,
    input  logic                   abort,
    output logic [2:0]             cmd_type,
    output logic [3:0]             cmd_port,
    output logic                   cmd_val,
    input  logic                   cmd_busy,
    input  logic                   cmd_done_good,
    input  logic                   cmd_done_bad,
    output logic                   res_val,
    output logic [2:0]             res_type,
    output logic [3:0]             res_port,
    output logic [1:0]             res_code,
    output logic [1:0]             res_retries
);

    localparam int unsigned    DEPTH   = 1 << QDEPTH_LOG2;
    localparam int unsigned    PW      = QDEPTH_LOG2 + 1;
    localparam int unsigned    RW      = (MAX_RETRY < 3) ? 2 : $clog2(MAX_RETRY + 1);
    localparam logic [19:0]    TLAST   = 20'(TIMEOUT - 1);
    localparam logic [RW-1:0]  RMAX    = RW'(MAX_RETRY);
    localparam logic [RW-1:0]  RSAT    = RW'(3);
    localparam logic [PW-1:0]  PTR_ONE = PW'(1);

    if (QDEPTH_LOG2 < 1) begin : g_bad_depth
        $error("QDEPTH_LOG2 must be at least 1");
    end
    if (TIMEOUT < 1 || (TIMEOUT - 1) >= (1 << 20)) begin : g_bad_timeout
        $error("TIMEOUT-1 must fit the 20-bit timer");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_REPORT} state_t;

    typedef struct packed {
        logic [2:0] typ;
        logic [3:0] port;
    } qent_t;

    qent_t          mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic           full, empty, push, pop;
    qent_t          head;

    state_t         state_q;
    logic [19:0]    timer_q;
    logic [RW-1:0]  retry_cnt_q;
    logic           res_val_q;
    logic [2:0]     res_type_q;
    logic [3:0]     res_port_q;
    logic [1:0]     res_code_q, res_retries_q;
    logic           fin;
    logic [1:0]     fin_code;
    logic [1:0]     retry_sat;

    // Pointer difference is the fill level; its MSB alone marks full.
    assign queue_level = wr_ptr_q - rd_ptr_q;
    assign full        = queue_level[QDEPTH_LOG2];
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign req_ready   = ~full & ~abort;
    assign push        = req_val & req_ready;
    assign pop         = (state_q == S_REPORT) & ~abort;
    assign head        = mem_q[rd_ptr_q[QDEPTH_LOG2-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) mem_q[wr_ptr_q[QDEPTH_LOG2-1:0]] <= '{typ: req_type, port: req_port};
        end
    end

    assign cmd_type = head.typ;
    assign cmd_port = head.port;
    assign cmd_val  = (state_q == S_ISSUE) & ~cmd_busy & ~abort;
    assign res_val  = res_val_q & ~abort;

    // Command completion in WAIT: good beats bad beats timeout.
    always_comb begin
        fin      = 1'b0;
        fin_code = 2'b00;
        if (state_q == S_WAIT) begin
            if (cmd_done_good) begin
                fin = 1'b1;
            end else if (cmd_done_bad) begin
                if (retry_cnt_q >= RMAX) begin
                    fin      = 1'b1;
                    fin_code = 2'b01;
                end
            end else if (timer_q == TLAST) begin
                fin      = 1'b1;
                fin_code = 2'b10;
            end
        end
    end

    assign retry_sat = (retry_cnt_q > RSAT) ? 2'd3 : retry_cnt_q[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            retry_cnt_q   <= '0;
            res_val_q     <= 1'b0;
            res_type_q    <= '0;
            res_port_q    <= '0;
            res_code_q    <= '0;
            res_retries_q <= '0;
        end else begin
            res_val_q <= 1'b0;
            if (abort) begin
                state_q     <= S_IDLE;
                timer_q     <= '0;
                retry_cnt_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (!empty) begin
                            state_q     <= S_ISSUE;
                            retry_cnt_q <= '0;
                        end
                    end
                    S_ISSUE: begin
                        if (cmd_val) begin
                            state_q <= S_WAIT;
                            timer_q <= '0;
                        end
                    end
                    S_WAIT: begin
                        timer_q <= timer_q + 20'd1;
                        if (fin) begin
                            state_q       <= S_REPORT;
                            res_val_q     <= 1'b1;
                            res_type_q    <= head.typ;
                            res_port_q    <= head.port;
                            res_code_q    <= fin_code;
                            res_retries_q <= retry_sat;
                        end else if (cmd_done_bad) begin
                            state_q     <= S_ISSUE;
                            retry_cnt_q <= retry_cnt_q + RW'(1);
                        end
                    end
                    S_REPORT: state_q <= S_IDLE;
                    default:  state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign res_type    = res_type_q;
    assign res_port    = res_port_q;
    assign res_code    = res_code_q;
    assign res_retries = res_retries_q;

endmodule

// File: tb/tb_sata_cmd_sequencer.sv
// Bench for sata_cmd_sequencer: queue-based transaction model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_sata_cmd_sequencer;

    localparam int QL    = 2;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;
    localparam int MR    = 2;

    logic         clk = 1'b0, rst = 1'b0;
    logic         req_val = 1'b0, abort = 1'b0, cmd_busy = 1'b0;
    logic         good = 1'b0, bad = 1'b0;
    logic [2:0]   req_type = '0;
    logic [3:0]   req_port = '0;
    logic         req_ready, cmd_val, res_val;
    logic [QL:0]  queue_level;
    logic [2:0]   cmd_type, res_type;
    logic [3:0]   cmd_port, res_port;
    logic [1:0]   res_code, res_retries;

    sata_cmd_sequencer #(.QDEPTH_LOG2(QL), .TIMEOUT(TMO), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst(rst), .req_val(req_val), .req_type(req_type), .req_port(req_port),
        .req_ready(req_ready), .queue_level(queue_level), .abort(abort),
        .cmd_type(cmd_type), .cmd_port(cmd_port), .cmd_val(cmd_val), .cmd_busy(cmd_busy),
        .cmd_done_good(good), .cmd_done_bad(bad), .res_val(res_val), .res_type(res_type),
        .res_port(res_port), .res_code(res_code), .res_retries(res_retries)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int n_acc = 0, n_res = 0;
    int a0 = 0, r0 = 0;

    function automatic void chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    // Model: pending requests, whether a command is being offered, how long it has waited,
    // how many re-issues it has had, and whether a result is being reported.
    logic [6:0] m_q[$];
    bit m_issuing = 0, m_rep = 0, m_res = 0;
    int m_age = -1, m_tries = 0;
    int m_rtype = 0, m_rport = 0, m_rcode = 0, m_rretr = 0;

    function automatic void m_finish(int code);
        m_age   = -1;
        m_rep   = 1;
        m_res   = 1;
        m_rtype = int'(m_q[0][6:4]);
        m_rport = int'(m_q[0][3:0]);
        m_rcode = code;
        m_rretr = (m_tries > 3) ? 3 : m_tries;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_q.delete();
            m_issuing = 0; m_rep = 0; m_res = 0; m_age = -1; m_tries = 0;
        end else begin
            int  pre;
            bit  acc_push;
            pre      = m_q.size();
            acc_push = req_val && !abort && pre < DEPTH;
            m_res    = 0;
            if (abort) begin
                m_q.delete();
                m_issuing = 0; m_rep = 0; m_age = -1; m_tries = 0;
            end else begin
                if (m_rep) begin
                    m_rep = 0;
                    void'(m_q.pop_front());
                end else if (m_issuing) begin
                    if (!cmd_busy) begin m_issuing = 0; m_age = 0; end
                end else if (m_age >= 0) begin
                    if (good) m_finish(0);
                    else if (bad) begin
                        if (m_tries < MR) begin m_tries++; m_age = -1; m_issuing = 1; end
                        else m_finish(1);
                    end else if (m_age == TMO - 1) m_finish(2);
                    else m_age++;
                end else if (pre > 0) begin
                    m_issuing = 1;
                    m_tries   = 0;
                end
                if (acc_push) m_q.push_back({req_type, req_port});
            end
        end
    end

    // Per-cycle comparison against the model, plus event counters for the directed checks.
    initial forever begin
        bit ecv, erv;
        @(negedge clk);
        #2;
        ecv = m_issuing && !cmd_busy && !abort && !rst;
        erv = m_res && !abort && !rst;
        chk("req_ready", int'(req_ready), int'(m_q.size() < DEPTH && !abort));
        chk("queue_level", int'(queue_level), m_q.size());
        chk("cmd_val", int'(cmd_val), int'(ecv));
        if (ecv) begin
            chk("cmd_type", int'(cmd_type), int'(m_q[0][6:4]));
            chk("cmd_port", int'(cmd_port), int'(m_q[0][3:0]));
        end
        chk("res_val", int'(res_val), int'(erv));
        if (erv) begin
            chk("res_type", int'(res_type), m_rtype);
            chk("res_port", int'(res_port), m_rport);
            chk("res_code", int'(res_code), m_rcode);
            chk("res_retries", int'(res_retries), m_rretr);
        end
        if (cmd_val) n_acc++;
        if (res_val) n_res++;
    end

    task automatic mark();
        a0 = n_acc;
        r0 = n_res;
    endtask

    task automatic push(input int t, input int p);
        req_val  = 1'b1;
        req_type = 3'(t);
        req_port = 4'(p);
        @(negedge clk);
        req_val  = 1'b0;
    endtask

    task automatic wait_cmd(input int max);
        bit ok = 0;
        for (int i = 0; i < max; i++) begin
            #1;
            if (cmd_val) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("wait_cmd", int'(ok), 1);
    endtask

    task automatic wait_res(input int max);
        bit ok = 0;
        for (int i = 0; i < max; i++) begin
            #1;
            if (res_val) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("wait_res", int'(ok), 1);
    endtask

    task automatic pulse(input bit g, input int dly);
        repeat (dly) @(negedge clk);
        if (g) good = 1'b1; else bad = 1'b1;
        @(negedge clk);
        good = 1'b0;
        bad  = 1'b0;
    endtask

    task automatic check_res(input string tag, input int nacc, input int code, input int retr,
                             input int typ, input int prt);
        chk({tag, " accepts"}, n_acc - a0, nacc);
        chk({tag, " code"}, int'(res_code), code);
        chk({tag, " retries"}, int'(res_retries), retr);
        chk({tag, " type"}, int'(res_type), typ);
        chk({tag, " port"}, int'(res_port), prt);
    endtask

    initial begin
        time t_cmd, t_res;
        int  cv;
        #1 rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst req_ready", int'(req_ready), 1);
        chk("rst queue_level", int'(queue_level), 0);
        chk("rst cmd_val", int'(cmd_val), 0);
        chk("rst cmd_type", int'(cmd_type), 0);
        chk("rst cmd_port", int'(cmd_port), 0);
        chk("rst res_val", int'(res_val), 0);
        chk("rst res_type", int'(res_type), 0);
        chk("rst res_port", int'(res_port), 0);
        chk("rst res_code", int'(res_code), 0);
        chk("rst res_retries", int'(res_retries), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single command, good after 5 cycles
        mark();
        push(3, 1);
        wait_cmd(10);
        pulse(1, 5);
        wait_res(10);
        check_res("t1", 1, 0, 0, 3, 1);
        @(negedge clk);
        chk("t1 results", n_res - r0, 1);

        // three bad answers exhaust the retries
        mark();
        push(5, 2);
        for (int k = 0; k < 3; k++) begin
            wait_cmd(20);
            pulse(0, 2);
        end
        wait_res(10);
        check_res("t2a", 3, 1, 2, 5, 2);
        @(negedge clk);

        // bad then good
        mark();
        push(6, 4);
        wait_cmd(20);
        pulse(0, 2);
        wait_cmd(20);
        pulse(1, 3);
        wait_res(10);
        check_res("t2b", 2, 0, 1, 6, 4);
        @(negedge clk);

        // timeout, then the queued command follows after the bubble
        mark();
        push(2, 7);
        push(4, 9);
        wait_cmd(10);
        t_cmd = $time;
        wait_res(40);
        t_res = $time;
        chk("t3 timeout latency", int'((t_res - t_cmd - 10) / 10), 16);
        check_res("t3 timeout", 1, 2, 0, 2, 7);
        wait_cmd(10);
        chk("t3 report-to-cmd gap", int'(($time - t_res) / 10), 2);
        chk("t3 next cmd_type", int'(cmd_type), 4);
        chk("t3 next cmd_port", int'(cmd_port), 9);
        pulse(1, 2);
        wait_res(10);
        check_res("t3 next", 2, 0, 0, 4, 9);
        @(negedge clk);

        // busy holds off the offer; done pulses while not waiting are ignored
        mark();
        cmd_busy = 1'b1;
        push(1, 3);
        cv = 0;
        for (int i = 0; i < 10; i++) begin
            good = (i == 3);
            bad  = (i == 6);
            #1;
            if (cmd_val) cv++;
            @(negedge clk);
        end
        good = 1'b0;
        bad  = 1'b0;
        chk("t4 cmd_val while busy", cv, 0);
        cmd_busy = 1'b0;
        #1;
        chk("t4 cmd_val on busy drop", int'(cmd_val), 1);
        pulse(1, 3);
        wait_res(10);
        check_res("t4", 1, 0, 0, 1, 3);
        @(negedge clk);
        chk("t4 results", n_res - r0, 1);

        // full queue: 5th push and a push on the REPORT cycle are rejected, order kept
        mark();
        cmd_busy = 1'b1;
        for (int k = 1; k <= 4; k++) push(k, k);
        #1;
        chk("t5 req_ready full", int'(req_ready), 0);
        chk("t5 level full", int'(queue_level), 4);
        @(negedge clk);
        push(5, 5);
        cmd_busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_cmd(10);
            chk("t5 cmd order", int'(cmd_type), k + 1);
            pulse(1, 1);
            wait_res(10);
            chk("t5 res order", int'(res_type), k + 1);
            if (k == 0) begin
                chk("t5 level at report", int'(queue_level), 4);
                req_val  = 1'b1;
                req_type = 3'd7;
                req_port = 4'd7;
                #1;
                chk("t5 req_ready at report", int'(req_ready), 0);
                @(negedge clk);
                req_val = 1'b0;
            end
        end
        repeat (6) @(negedge clk);
        #1;
        chk("t5 level drained", int'(queue_level), 0);
        chk("t5 accepts", n_acc - a0, 4);
        chk("t5 results", n_res - r0, 4);
        @(negedge clk);

        // abort in WAIT with 3 queued; late done ignored
        mark();
        cmd_busy = 1'b1;
        push(1, 8);
        push(2, 9);
        push(3, 10);
        cmd_busy = 1'b0;
        wait_cmd(10);
        repeat (2) @(negedge clk);
        abort    = 1'b1;
        req_val  = 1'b1;
        req_type = 3'd5;
        req_port = 4'd5;
        #1;
        chk("t6 req_ready in abort", int'(req_ready), 0);
        @(negedge clk);
        abort   = 1'b0;
        req_val = 1'b0;
        #1;
        chk("t6 level after abort", int'(queue_level), 0);
        pulse(1, 1);
        repeat (5) @(negedge clk);
        chk("t6 results", n_res - r0, 0);
        chk("t6 accepts", n_acc - a0, 1);

        // abort landing on the REPORT cycle suppresses the result
        mark();
        push(6, 6);
        wait_cmd(10);
        pulse(1, 2);
        abort = 1'b1;
        #1;
        chk("t6 res_val abort in report", int'(res_val), 0);
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("t6 level after report abort", int'(queue_level), 0);
        repeat (3) @(negedge clk);
        chk("t6 report abort results", n_res - r0, 0);

        // async reset mid-ISSUE
        push(2, 5);
        wait_cmd(10);
        #2;
        rst = 1'b1;
        #1;
        chk("t6 cmd_val async reset", int'(cmd_val), 0);
        chk("t6 level async reset", int'(queue_level), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("t6 idle after reset", int'(cmd_val), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
